isqrt_seq_engine: RTL and testbench

Multi-cycle integer square-root engine. It computes the root and remainder of an unsigned radical using the restoring digit-by-digit method, one root bit per clock. It sits directly downstream of the radical CSR in the soft-processor unit-test designs and drives the Q and remainder CSR read inputs. It is a synthesizable, deterministic-latency replacement for the vendor square-root IP.

---
 rtl/isqrt_pkg.sv | 20 ++
 rtl/isqrt_step.sv | 26 ++
 rtl/isqrt_seq_engine.sv | 100 ++++++++++
 tb/tb_isqrt_seq_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the sequential integer square-root engine.
package isqrt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } isqrt_state_e;

    localparam int unsigned RADICAL_W_DEFAULT = 8;

    function automatic int unsigned isqrt_q_w(input int unsigned radical_w);
        return radical_w / 2;
    endfunction

    // The remainder needs one bit more than the root, since it can reach 2*q.
    function automatic int unsigned isqrt_rem_w(input int unsigned radical_w);
        return radical_w / 2 + 1;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root iteration; purely combinational.
module isqrt_step #(
    parameter int unsigned Q_W   = 4,
    parameter int unsigned REM_W = Q_W + 1
) (
    input  logic [REM_W:0] prem,
    input  logic [Q_W-1:0] root,
    input  logic [1:0]     digit,
    output logic [REM_W:0] prem_next,
    output logic [Q_W-1:0] root_next
);

    logic [REM_W+1:0] t;
    logic [REM_W+1:0] trial;
    logic [REM_W+1:0] diff;
    logic             ge;

    // prem never exceeds 2*root, so dropping its guard bit here loses nothing.
    assign t         = (REM_W + 2)'({prem, digit});
    assign trial     = {1'b0, root, 2'b01};
    assign diff      = t - trial;
    assign ge        = (t >= trial);
    assign prem_next = ge ? diff[REM_W:0] : t[REM_W:0];
    assign root_next = Q_W'({root, ge});

endmodule

// File: rtl/isqrt_seq_engine.sv
// Multi-cycle integer square root, one root bit per clock.
// Optional: define ISQRT_AUTOSTART_EN to start automatically when radical changes.
module isqrt_seq_engine
    import isqrt_pkg::*;
#(
    parameter int unsigned RADICAL_W = RADICAL_W_DEFAULT,
    parameter int unsigned Q_W       = isqrt_q_w(RADICAL_W),
    parameter int unsigned REM_W     = isqrt_rem_w(RADICAL_W)
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic [RADICAL_W-1:0] radical,
    input  logic                 start,
    output logic [Q_W-1:0]       q,
    output logic [REM_W-1:0]     remainder,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

    isqrt_state_e         state;
    logic [RADICAL_W-1:0] op;
    logic [Q_W-1:0]       root;
    logic [REM_W:0]       prem;
    logic [CNT_W-1:0]     cnt;
    logic [Q_W-1:0]       root_nxt;
    logic [REM_W:0]       prem_nxt;
    logic                 start_go;

`ifdef ISQRT_AUTOSTART_EN
    logic [RADICAL_W-1:0] last_op;

    // A radical that differs from the last one computed acts as an implicit start.
    assign start_go = start | (radical != last_op);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            last_op <= '0;
        end else if (state == IDLE && start_go) begin
            last_op <= radical;
        end
    end
`else
    assign start_go = start;
`endif

    isqrt_step #(
        .Q_W   (Q_W),
        .REM_W (REM_W)
    ) u_step (
        .prem      (prem),
        .root      (root),
        .digit     (op[RADICAL_W-1 -: 2]),
        .prem_next (prem_nxt),
        .root_next (root_nxt)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            op        <= '0;
            root      <= '0;
            prem      <= '0;
            cnt       <= '0;
            q         <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_go) begin
                        op    <= radical;
                        root  <= '0;
                        prem  <= '0;
                        cnt   <= CNT_W'(Q_W - 1);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    op   <= op << 2;
                    root <= root_nxt;
                    prem <= prem_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        q         <= root_nxt;
                        remainder <= prem_nxt[REM_W-1:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_seq_engine.sv
// Directed and sweep bench for isqrt_seq_engine at the default 8-bit radical width.
module tb_isqrt_seq_engine;

    localparam int unsigned RW  = 8;
    localparam int unsigned QW  = 4;
    localparam int unsigned RMW = 5;

    logic          clk      = 1'b0;
    logic          areset_n = 1'b1;
    logic          start    = 1'b0;
    logic [RW-1:0] radical  = '0;
    logic [QW-1:0] q;
    logic [RMW-1:0] remainder;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    isqrt_seq_engine dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .radical   (radical),
        .start     (start),
        .q         (q),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
    );

    // Reference chain of step instances, fed with the radical of the operation in flight.
    logic [RW-1:0] ref_rad = '0;
    logic [RMW:0]  m_prem [0:QW];
    logic [QW-1:0] m_root [0:QW];

    assign m_prem[0] = '0;
    assign m_root[0] = '0;

    for (genvar i = 0; i < QW; i++) begin : g_model
        isqrt_step #(
            .Q_W   (QW),
            .REM_W (RMW)
        ) u_step (
            .prem      (m_prem[i]),
            .root      (m_root[i]),
            .digit     (ref_rad[RW-1-2*i -: 2]),
            .prem_next (m_prem[i+1]),
            .root_next (m_root[i+1])
        );
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned ref_sqrt(input int unsigned r);
        int unsigned k = 0;
        while ((k + 1) * (k + 1) <= r) k++;
        return k;
    endfunction

    task automatic do_sqrt(input logic [RW-1:0] rad, input int unsigned eq, input int unsigned er,
                           input string tag);
        int lat = 0;
        int busy_cycles = 0;
        radical = rad;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, "_busy_after_start"}, busy, 1);
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 4);
        check_eq({tag, "_busy_cycles"}, busy_cycles, 4);
        check_eq({tag, "_busy_at_done"}, busy, 0);
        check_eq({tag, "_q"}, q, eq);
        check_eq({tag, "_rem"}, remainder, er);
        tick();
        check_eq({tag, "_done_one_cycle"}, done, 0);
        check_eq({tag, "_q_hold"}, q, eq);
    endtask

    initial begin
        int n_done;
        int done_at;
        int seen_q;
        int seen_rem;
        int prev;
        int w;

        #2 areset_n = 1'b0;
        #1;
        check_eq("reset_q", q, 0);
        check_eq("reset_rem", remainder, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        tick();
        tick();
        areset_n = 1'b1;
        tick();

`ifdef ISQRT_AUTOSTART_EN
        radical = 8'd16;
        n_done  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 1) radical = 8'd17;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    check_eq("auto_first_q", q, 4);
                    check_eq("auto_first_rem", remainder, 0);
                end else if (n_done == 2) begin
                    check_eq("auto_rerun_q", q, 4);
                    check_eq("auto_rerun_rem", remainder, 1);
                end
            end
        end
        check_eq("auto_done_count", n_done, 2);
`endif

        do_sqrt(8'd200, 14, 4, "r200");
        do_sqrt(8'd255, 15, 30, "r255");
        do_sqrt(8'd144, 12, 0, "r144");
        do_sqrt(8'd0, 0, 0, "r0");

        // Second start during CALC must be ignored, and radical changes must not leak in.
        radical = 8'd50;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        radical = 8'd99;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        radical = 8'd50;
        n_done  = 0;
        done_at = -1;
        seen_q  = -1;
        seen_rem = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at  = i;
                    seen_q   = q;
                    seen_rem = remainder;
                end
            end
        end
        check_eq("ignore_done_count", n_done, 1);
        check_eq("ignore_done_edge", done_at, 1);
        check_eq("ignore_q", seen_q, 7);
        check_eq("ignore_rem", seen_rem, 1);

        // Reset in the middle of CALC.
        radical = 8'd200;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        areset_n = 1'b0;
        radical  = 8'd0;
        #1;
        check_eq("midreset_q", q, 0);
        check_eq("midreset_rem", remainder, 0);
        check_eq("midreset_busy", busy, 0);
        check_eq("midreset_done", done, 0);
        tick();
        areset_n = 1'b1;
        n_done   = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) n_done++;
        end
        check_eq("midreset_no_done", n_done, 0);
        do_sqrt(8'd81, 9, 0, "r81");

        // Exhaustive back-to-back sweep.
        prev = 0;
        for (int r = 0; r < 256; r++) begin
            radical = r[RW-1:0];
            start   = 1'b1;
            tick();
            start   = 1'b0;
            ref_rad = r[RW-1:0];
            w = 0;
            while (!done && w < 20) begin
                tick();
                w++;
            end
            check_eq("sweep_done", done, 1);
            if (r > 0) check_eq("sweep_spacing", cycle - prev, 5);
            prev = cycle;
            check_eq("sweep_q_model", q, m_root[QW]);
            check_eq("sweep_rem_model", remainder, m_prem[QW]);
            check_eq("sweep_q_floor", q, ref_sqrt(r));
            check_eq("sweep_rem_floor", remainder, r - ref_sqrt(r) * ref_sqrt(r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
